// File: rtl/timer_counter.sv
// Prescaled up/down/up-down timer with shadowed period, compare and prescale settings.
// Latency: out/dir/halted update on the edge after a tick; ovf/unf pulse the cycle after the boundary tick.
// Backpressure: none; ena gates counting, load overrides counting, one-shot halts until the next load.
module timer_counter #(
  parameter int BITS       = 8,
  parameter int PRESC_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  oneshot,
  input  logic [BITS-1:0]       top,
  input  logic [BITS-1:0]       cmp,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic [BITS-1:0]       value,
  input  logic                  load,
  output logic [BITS-1:0]       out,
  output logic                  dir,
  output logic                  ovf,
  output logic                  unf,
  output logic                  cmp_out,
  output logic                  halted
);

  localparam logic [BITS-1:0]       CNT_ONE   = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [PRESC_BITS-1:0] PRESC_ONE = {{(PRESC_BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0]       cnt_q, cnt_d;
  logic [PRESC_BITS-1:0] pcnt_q, pcnt_d;
  logic                  dir_q, dir_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  halted_q, halted_d;
  logic                  primed_q;
  logic [BITS-1:0]       top_sh_q, top_sh_d;
  logic [BITS-1:0]       cmp_sh_q, cmp_sh_d;
  logic [PRESC_BITS-1:0] presc_sh_q, presc_sh_d;

  logic active;
  logic tick;
  logic upd_evt;
  logic is_down;
  logic is_updown;

  // Mode 11 falls through to plain up counting.
  assign is_down   = (mode == 2'b01);
  assign is_updown = (mode == 2'b10);
  assign active    = primed_q & ena & ~halted_q & ~load;
  assign tick      = active & (pcnt_q == presc_sh_q);

  // Counter, prescaler, direction and boundary pulse next-state.
  always_comb begin
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    dir_d    = dir_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    halted_d = halted_q;
    upd_evt  = 1'b0;
    if (load) begin
      cnt_d    = value;
      dir_d    = ~is_down;
      halted_d = 1'b0;
      pcnt_d   = '0;
    end else if (!active) begin
      pcnt_d = '0;
    end else if (!tick) begin
      pcnt_d = pcnt_q + PRESC_ONE;
    end else begin
      pcnt_d = '0;
      if (is_updown) begin
        if (dir_q) begin
          if (cnt_q >= top_sh_q) begin
            // Turn around at the top; a zero period pins the count at 0.
            dir_d = 1'b0;
            ovf_d = 1'b1;
            cnt_d = (top_sh_q == '0) ? '0 : top_sh_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            // Bottom turnaround closes the period and reloads the shadows.
            dir_d   = 1'b1;
            unf_d   = 1'b1;
            upd_evt = 1'b1;
            cnt_d   = (top_sh_q == '0) ? '0 : CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end else if (is_down) begin
        dir_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = top_sh_q;
          unf_d   = 1'b1;
          upd_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else begin
        dir_d = 1'b1;
        if (cnt_q >= top_sh_q) begin
          cnt_d   = '0;
          ovf_d   = 1'b1;
          upd_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // The boundary action above still happens; only further counting stops.
      if (upd_evt && oneshot) halted_d = 1'b1;
    end
  end

  // Shadows track the inputs whenever counting cannot observe a mid-period change.
  always_comb begin
    top_sh_d   = top_sh_q;
    cmp_sh_d   = cmp_sh_q;
    presc_sh_d = presc_sh_q;
    if (!primed_q || load || !ena || halted_q || upd_evt) begin
      top_sh_d   = top;
      cmp_sh_d   = cmp;
      presc_sh_d = presc;
    end
  end

  // State registers; reset aborts any period in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      pcnt_q     <= '0;
      dir_q      <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      halted_q   <= 1'b0;
      primed_q   <= 1'b0;
      top_sh_q   <= '0;
      cmp_sh_q   <= '0;
      presc_sh_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      dir_q      <= dir_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      halted_q   <= halted_d;
      primed_q   <= 1'b1;
      top_sh_q   <= top_sh_d;
      cmp_sh_q   <= cmp_sh_d;
      presc_sh_q <= presc_sh_d;
    end
  end

  assign out     = cnt_q;
  assign dir     = dir_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign halted  = halted_q;
  // Decoded purely from registers so it is glitch-free.
  assign cmp_out = (cnt_q < cmp_sh_q);

endmodule

// File: tb/tb_timer_counter.sv
// Directed scenarios for timer_counter (BITS=4) with expected outputs queued per cycle.
// Latency: each step pushes the expected post-edge state, then pops and compares #1 after the edge.
// Backpressure: none; the bench drives every input directly.
module tb_timer_counter;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [1:0] mode;
  logic       oneshot;
  logic [3:0] top;
  logic [3:0] cmp;
  logic [3:0] presc;
  logic [3:0] value;
  logic       load;
  logic [3:0] out;
  logic       dir;
  logic       ovf;
  logic       unf;
  logic       cmp_out;
  logic       halted;

  typedef struct packed {
    logic [3:0] o;
    logic       d;
    logic       ov;
    logic       un;
    logic       c;
    logic       h;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string scen     = "reset";

  logic [3:0] ud_o [10] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2};
  logic       ud_d [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  timer_counter #(.BITS(4), .PRESC_BITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .mode    (mode),
    .oneshot (oneshot),
    .top     (top),
    .cmp     (cmp),
    .presc   (presc),
    .value   (value),
    .load    (load),
    .out     (out),
    .dir     (dir),
    .ovf     (ovf),
    .unf     (unf),
    .cmp_out (cmp_out),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", scen, tag, got, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("out",     32'(out),     32'(e.o));
    check("dir",     32'(dir),     32'(e.d));
    check("ovf",     32'(ovf),     32'(e.ov));
    check("unf",     32'(unf),     32'(e.un));
    check("cmp_out", 32'(cmp_out), 32'(e.c));
    check("halted",  32'(halted),  32'(e.h));
  endtask

  // Queue the state expected after the next edge, then compare it once the DUT has moved.
  task automatic step(input logic [3:0] o, input logic d, input logic ov,
                      input logic un, input logic c, input logic h);
    exp_t e;
    exp_t got_e;
    e.o = o; e.d = d; e.ov = ov; e.un = un; e.c = c; e.h = h;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check_all(got_e);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    exp_t       r;
    rst = 1'b1; ena = 1'b1; mode = 2'b00; oneshot = 1'b0; top = 4'd5; cmp = 4'd3;
    presc = 4'd0; value = 4'd0; load = 1'b0;
    #2 rst = 1'b0;
    #10;
    r.o = 4'd0; r.d = 1'b1; r.ov = 1'b0; r.un = 1'b0; r.c = 1'b0; r.h = 1'b0;
    check_all(r);
    @(posedge clk);
    #1 rst = 1'b1;

    // Up, top=5, presc=0: prime cycle, then 1..5,0 with ovf on each wrap.
    scen = "up";
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      v = 4'(k % 6);
      step(v, 1'b1, v == 4'd0, 1'b0, v < 4'd3, 1'b0);
    end

    // Down, presc=2, top=3: each value held three cycles, unf after 0->3.
    scen = "down";
    mode = 2'b01; presc = 4'd2; top = 4'd3; cmp = 4'd0; value = 4'd3; load = 1'b1;
    step(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      v = 4'(3 - ((k / 3) % 4));
      step(v, 1'b0, 1'b0, k == 12, 1'b0, 1'b0);
    end

    // Up-down, top=3, cmp=2.
    scen = "updown";
    mode = 2'b10; presc = 4'd0; top = 4'd3; cmp = 4'd2; value = 4'd0; load = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(ud_o[k], ud_d[k], (k == 3) || (k == 9), k == 6, ud_o[k] < 4'd2, 1'b0);
    end

    // Up-down with a zero period: count pinned at 0, ovf/unf alternate.
    scen = "updown_top0";
    top = 4'd0; cmp = 4'd0; value = 4'd0; load = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(4'd0, k % 2 == 0, k % 2 == 1, k % 2 == 0, 1'b0, 1'b0);
    end

    // One-shot up, top=2: single wrap then frozen; a load restarts it.
    scen = "oneshot";
    mode = 2'b00; oneshot = 1'b1; top = 4'd2; value = 4'd0; load = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    value = 4'd1; load = 1'b1;
    step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    oneshot = 1'b0;

    // Period change mid-count only lands at the next wrap.
    scen = "shadow";
    top = 4'd7; value = 4'd0; load = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    top = 4'd3;
    for (int k = 3; k <= 7; k++) step(4'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count, then prime cycle and fresh count; ena=0 holds.
    scen = "async_rst";
    top = 4'd7; cmp = 4'd4; value = 4'd0; load = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 6; k++) step(4'(k), 1'b1, 1'b0, 1'b0, k < 4, 1'b0);
    #2 rst = 1'b0;
    #1;
    r.o = 4'd0; r.d = 1'b1; r.ov = 1'b0; r.un = 1'b0; r.c = 1'b0; r.h = 1'b0;
    check_all(r);
    @(posedge clk);
    #1 rst = 1'b1;
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ena = 1'b0;
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ena = 1'b1;
    step(4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    scen = "end";
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter BITS, default 8, counter width (>=2).
REQ-002 SHALL have parameter PRESC_BITS, default 4, prescaler width (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  count enable.
REQ-006 SHALL have port mode  input  2  00 up, 01 down, 10 up-down, 11 treated as 00.
REQ-007 SHALL have port oneshot  input  1  halt at first period boundary.
REQ-008 SHALL have port top  input  BITS  period limit.
REQ-009 SHALL have port cmp  input  BITS  compare threshold.
REQ-010 SHALL have port presc  input  PRESC_BITS  prescale divisor minus one.
REQ-011 SHALL have port value  input  BITS  load value.
REQ-012 SHALL have port load  input  1  synchronous load strobe.
REQ-013 SHALL have port out  output  BITS  counter value.
REQ-014 SHALL have port dir  output  1  1 = counting up.
REQ-015 SHALL have port ovf  output  1  one-cycle pulse, top boundary.
REQ-016 SHALL have port unf  output  1  one-cycle pulse, zero boundary.
REQ-017 SHALL have port cmp_out  output  1  out < cmp_sh, decoded from registers only.
REQ-018 SHALL have port halted  output  1  one-shot finished.

Function
REQ-019 SHALL hold shadow registers top_sh, cmp_sh, presc_sh; counting uses only shadows.
REQ-020 SHALL copy top/cmp/presc into shadows when: first clock after reset release (prime cycle, no counting), load=1, inactive (ena=0 or halted=1), or update event.
REQ-021 Active = primed & ena & ~halted & ~load.
REQ-022 Prescaler pcnt: increments on active cycles; tick when pcnt==presc_sh, pcnt<=0 on tick; presc=0 gives tick every active cycle; pcnt<=0 on load and when inactive.
REQ-023 Up mode, tick: cnt>=top_sh -> cnt<=0, ovf pulse, update event; else cnt+1; dir=1.
REQ-024 Down mode, tick: cnt==0 -> cnt<=top_sh, unf pulse, update event; else cnt-1; dir=0.
REQ-025 Up-down, tick, dir=1: cnt>=top_sh -> dir<=0, cnt<=top_sh-1, ovf pulse; else cnt+1.
REQ-026 Up-down, tick, dir=0: cnt==0 -> dir<=1, cnt<=1, unf pulse, update event; else cnt-1.
REQ-027 Up-down with top_sh==0: cnt stays 0, ovf and unf pulse alternately each tick.
REQ-028 ovf/unf registered: asserted exactly the cycle after the boundary tick, one cycle wide.
REQ-029 oneshot=1 at update event: boundary action still applied (wrap/reload, pulse), then halted<=1.
REQ-030 load=1 (priority over counting): cnt<=value, dir<=(mode!=01), halted<=0, pcnt<=0, no pulses.
REQ-031 Mode change while active: takes effect next tick; entering up/down sets dir per REQ-023/024; entering up-down keeps dir.
REQ-032 cmp_out: cmp_sh=0 -> always 0; cmp_sh > top_sh -> always 1 while counting.
REQ-033 All arithmetic modulo 2^BITS; no intermediate wider than BITS+1.

Reset
REQ-034 rst=0 SHALL immediately clear: cnt=0, pcnt=0, dir=1, ovf=0, unf=0, halted=0, primed=0, shadows=0.
REQ-035 Reset mid-count SHALL abort the period; after release one prime cycle, then counting from 0 with fresh shadows.

Verification (BITS=4)
REQ-036 Up, presc=0, top=5, ena=1 -> out 0,1,2,3,4,5,0...; ovf high one cycle after each 5->0.
REQ-037 Down, presc=2, top=3 -> each value held 3 cycles: 3,2,1,0,3; unf pulse after 0->3.
REQ-038 Up-down, top=3 -> 0,1,2,3,2,1,0,1; ovf after 3, unf after 0; cmp=2 gives cmp_out=1 on 0,1 only.
REQ-039 Up, oneshot=1, top=2 -> 0,1,2,0 then halted=1, out frozen at 0, single ovf; load value=1 -> halted=0, resumes 1,2.
REQ-040 Up, top=7, change top to 3 at out=2 -> continues to 7 then wraps; next period ends at 3.
REQ-041 rst low asynchronously at out=6 -> out=0 without clock edge; release -> prime cycle, then 0,1,2.
